// File: rtl/instr_fetch_seq_if.sv
// Fetch sequencer bus: instruction memory port plus the
// valid/ready instruction handshake towards the datapath.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 5
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       next_pc;
    logic              flush;
    logic [31:0]       flush_pc;
    logic              misaligned;
    logic [31:0]       fetch_count;

    modport master (
        output mem_rd, mem_addr, instr, pc, instr_valid,
        output misaligned, fetch_count,
        input  mem_data, instr_ready, next_pc, flush, flush_pc
    );

    modport slave (
        input  mem_rd, mem_addr, instr, pc, instr_valid,
        input  misaligned, fetch_count,
        output mem_data, instr_ready, next_pc, flush, flush_pc
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Multi-cycle fetch: four byte reads assembled big-endian
// into one instruction word, offered over valid/ready.
module instr_fetch_seq #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_seq_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic        r_valid;
    logic        w_flush;
    logic        w_accept;

    assign w_flush  = bus.flush && (r_state != IDLE);
    assign w_accept = (r_state == HOLD) && bus.instr_ready && !w_flush;

    // State and byte counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode; a redirect overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                w_cnt_nxt   = 2'd0;
            end
            FETCH: begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    w_state_nxt = FETCH;
                    w_cnt_nxt   = 2'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
        if (w_flush) begin
            w_state_nxt = FETCH;
            w_cnt_nxt   = 2'd0;
        end
    end

    // PC, accepted-instruction counter and registered valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_count <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_nxt == HOLD);
            if (w_flush) begin
                r_pc <= bus.flush_pc;
            end else if (w_accept) begin
                r_pc    <= bus.next_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Byte capture: the byte read last cycle lands in its lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'd0;
        end else if (!w_flush) begin
            if (r_state == FETCH) begin
                case (r_cnt)
                    2'd1:    r_instr[31:24] <= bus.mem_data;
                    2'd2:    r_instr[23:16] <= bus.mem_data;
                    2'd3:    r_instr[15:8]  <= bus.mem_data;
                    default: ;
                endcase
            end else if (r_state == DRAIN) begin
                r_instr[7:0] <= bus.mem_data;
            end
        end
    end

    assign bus.mem_rd      = (r_state == FETCH);
    assign bus.mem_addr    = (r_state == FETCH)
                           ? r_pc[ADDR_W-1:0] + ADDR_W'(r_cnt)
                           : r_pc[ADDR_W-1:0];
    assign bus.instr       = r_instr;
    assign bus.pc          = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.misaligned  = r_valid && (r_pc[1:0] != 2'b00);
    assign bus.fetch_count = r_count;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios plus random
// handshake traffic against a cycle-level reference model.
module tb_instr_fetch_seq;
    logic clk;
    logic rst_n;

    instr_fetch_seq_if #(.ADDR_W(5)) bus ();

    instr_fetch_seq #(
        .ADDR_W  (5),
        .RESET_PC(32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] mem [32];
    int         checks;
    int         errors;

    // Model: phase -1 idle, 0..3 reads, 4 last byte, 5 offering
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory, one cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    function automatic logic [31:0] word_at(logic [31:0] p);
        logic [4:0] a;
        a = p[4:0];
        return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= -1;
            m_pc    <= 32'h0;
            m_count <= 32'h0;
        end else if (m_phase == -1) begin
            m_phase <= 0;
        end else if (bus.flush) begin
            m_pc    <= bus.flush_pc;
            m_phase <= 0;
        end else if (m_phase == 5) begin
            if (bus.instr_ready) begin
                m_pc    <= bus.next_pc;
                m_count <= m_count + 32'd1;
                m_phase <= 0;
            end
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic       v;
            logic       rd;
            logic [4:0] a;
            v  = (m_phase == 5);
            rd = (m_phase >= 0) && (m_phase <= 3);
            a  = rd ? m_pc[4:0] + 5'(m_phase) : m_pc[4:0];
            chk("instr_valid", 32'(bus.instr_valid), 32'(v));
            chk("mem_rd", 32'(bus.mem_rd), 32'(rd));
            chk("mem_addr", 32'(bus.mem_addr), 32'(a));
            chk("pc", bus.pc, m_pc);
            chk("fetch_count", bus.fetch_count, m_count);
            chk("misaligned", 32'(bus.misaligned),
                32'(v && (m_pc[1:0] != 2'b00)));
            if (v) chk("instr", bus.instr, word_at(m_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (bus.instr_valid) break;
        end
    endtask

    task automatic reset_start();
        int n;
        step();
        rst_n = 1'b1;
        wait_valid(n);
        chk("first_latency", n, 6);
        chk("first_instr", bus.instr, 32'h8CA40004);
        chk("first_pc", bus.pc, 32'h0);
    endtask

    initial begin
        int          n;
        logic [31:0] cnt_s;
        logic [31:0] ins_s;
        logic [4:0]  seq [4];
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C;
        mem[1] = 8'hA4;
        mem[2] = 8'h00;
        mem[3] = 8'h04;
        bus.mem_data    = 8'h00;
        bus.instr_ready = 1'b1;
        bus.next_pc     = 32'h4;
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        rst_n           = 1'b0;
        #1;
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        repeat (2) step();

        reset_start();
        wait_valid(n);
        chk("second_latency", n, 6);
        chk("second_pc", bus.pc, 32'h4);

        bus.instr_ready = 1'b0;
        ins_s = bus.instr;
        cnt_s = bus.fetch_count;
        chk("count_before_hold", cnt_s, 32'd1);
        repeat (10) begin
            step();
            chk("hold_valid", 32'(bus.instr_valid), 32'h1);
            chk("hold_rd", 32'(bus.mem_rd), 32'h0);
            chk("hold_instr", bus.instr, ins_s);
            chk("hold_count", bus.fetch_count, cnt_s);
        end
        bus.instr_ready = 1'b1;
        bus.next_pc     = 32'h1E;
        step();
        chk("accept_count", bus.fetch_count, cnt_s + 32'd1);

        bus.next_pc = 32'h22;
        for (int i = 0; i < 4; i++) begin
            seq[i] = bus.mem_addr;
            step();
        end
        chk("wrap_a0", 32'(seq[0]), 32'h1E);
        chk("wrap_a1", 32'(seq[1]), 32'h1F);
        chk("wrap_a2", 32'(seq[2]), 32'h00);
        chk("wrap_a3", 32'(seq[3]), 32'h01);
        bus.instr_ready = 1'b0;
        wait_valid(n);
        chk("wrap_valid", 32'(bus.instr_valid), 32'h1);
        chk("wrap_instr", bus.instr,
            {mem[30], mem[31], 8'h8C, 8'hA4});
        chk("wrap_misaligned", 32'(bus.misaligned), 32'h1);

        bus.instr_ready = 1'b1;
        bus.next_pc     = 32'h20;
        step();
        bus.instr_ready = 1'b0;
        repeat (2) step();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h10;
        step();
        bus.flush = 1'b0;
        wait_valid(n);
        chk("flush_latency", n + 1, 6);
        chk("flush_pc", bus.pc, 32'h10);
        chk("flush_instr", bus.instr,
            {mem[16], mem[17], mem[18], mem[19]});

        cnt_s           = bus.fetch_count;
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h108;
        bus.instr_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("hflush_valid", 32'(bus.instr_valid), 32'h0);
        chk("hflush_pc", bus.pc, 32'h108);
        chk("hflush_count", bus.fetch_count, cnt_s);

        repeat (400) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            bus.flush_pc    = $urandom;
            bus.next_pc     = ($urandom_range(0, 1) != 0)
                            ? m_pc + 32'd4 : $urandom;
            step();
        end
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        bus.next_pc     = 32'h8;

        n = 0;
        while (!bus.mem_rd && n < 20) begin
            step();
            n++;
        end
        chk("mid_fetch_found", 32'(bus.mem_rd), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd", 32'(bus.mem_rd), 32'h0);
        chk("arst_valid", 32'(bus.instr_valid), 32'h0);
        chk("arst_count", bus.fetch_count, 32'h0);
        chk("arst_instr", bus.instr, 32'h0);
        chk("arst_pc", bus.pc, 32'h0);
        bus.next_pc = 32'h4;
        repeat (2) step();
        reset_start();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
